// File: rtl/result_demux_pkg.sv
// Shared widths, destination select codes and slot state encoding for result_demux.
// Combinational-only content; no latency or backpressure of its own.
package result_demux_pkg;

    localparam int         DATA_W_DEF = 64;
    localparam int         NUM_OUT    = 5;
    localparam int         SEL_W      = 3;
    localparam int         DROP_W     = 8;

    localparam logic [SEL_W-1:0] SEL_OUT1 = 3'b000;
    localparam logic [SEL_W-1:0] SEL_OUT2 = 3'b001;
    localparam logic [SEL_W-1:0] SEL_OUT3 = 3'b010;
    localparam logic [SEL_W-1:0] SEL_OUT4 = 3'b011;
    localparam logic [SEL_W-1:0] SEL_OUT5 = 3'b100;

    localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Codes above the last destination are accepted and discarded.
    function automatic logic is_drop_sel(input logic [SEL_W-1:0] sel);
        return sel > SEL_OUT5;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready output buffer; loaded word is visible the cycle after load.
// Drain is ignored while empty; load while full is only legal with a same-cycle drain.
module demux_slot
    import result_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_drain,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    slot_state_t       r_state;
    slot_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: begin
                if (i_load) begin
                    w_state_nxt = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                // A drain with a simultaneous load keeps the slot full with the new word.
                if (!i_load && i_drain) begin
                    w_state_nxt = SLOT_EMPTY;
                end
            end
            default: w_state_nxt = SLOT_EMPTY;
        endcase
    end

    assign o_data  = r_data;
    assign o_valid = (r_state == SLOT_FULL);

endmodule

// File: rtl/result_demux.sv
// Routes result words to one of five one-entry output buffers, 1-cycle latency; bad selects are counted and dropped.
// InReady falls only when the selected buffer is full and not being drained this cycle.
module result_demux
    import result_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   In,
    input  logic                InValid,
    output logic                InReady,
    input  logic [SEL_W-1:0]    Control,
    output logic [DATA_W-1:0]   Out1,
    output logic [DATA_W-1:0]   Out2,
    output logic [DATA_W-1:0]   Out3,
    output logic [DATA_W-1:0]   Out4,
    output logic [DATA_W-1:0]   Out5,
    output logic [NUM_OUT-1:0]  OutValid,
    input  logic [NUM_OUT-1:0]  OutReady,
    output logic [DROP_W-1:0]   DropCount
);

    logic [NUM_OUT-1:0] w_sel;
    logic [NUM_OUT-1:0] w_load;
    logic               w_drop;
    logic               w_accept;
    logic [DATA_W-1:0]  w_out [NUM_OUT];
    logic [DROP_W-1:0]  r_drop_cnt;

    always_comb begin
        w_sel  = '0;
        w_drop = is_drop_sel(Control);
        case (Control)
            SEL_OUT1: w_sel[0] = 1'b1;
            SEL_OUT2: w_sel[1] = 1'b1;
            SEL_OUT3: w_sel[2] = 1'b1;
            SEL_OUT4: w_sel[3] = 1'b1;
            SEL_OUT5: w_sel[4] = 1'b1;
            default:  w_sel    = '0;
        endcase
    end

    assign InReady  = !reset && (w_drop || (|(w_sel & (~OutValid | OutReady))));
    assign w_accept = InValid && InReady;
    assign w_load   = w_sel & {NUM_OUT{w_accept}};

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_load[k]),
            .i_data  (In),
            .i_drain (OutReady[k]),
            .o_data  (w_out[k]),
            .o_valid (OutValid[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_drop && (r_drop_cnt != DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign DropCount = r_drop_cnt;
    assign Out1      = w_out[0];
    assign Out2      = w_out[1];
    assign Out3      = w_out[2];
    assign Out4      = w_out[3];
    assign Out5      = w_out[4];

endmodule

// File: tb/tb_result_demux.sv
// Scoreboard bench for result_demux: directed scenarios plus a random soak,
// with a negedge monitor comparing outputs against per-destination expected queues.
module tb_result_demux;

    logic        clk;
    logic        reset;
    logic [63:0] In;
    logic        InValid;
    logic        InReady;
    logic [2:0]  Control;
    logic [63:0] Out1, Out2, Out3, Out4, Out5;
    logic [4:0]  OutValid;
    logic [4:0]  OutReady;
    logic [7:0]  DropCount;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q [5][$];
    int          exp_drop = 0;
    logic [4:0]  m_occ;
    logic        m_rdy;
    logic [63:0] outs [5];

    result_demux #(.DATA_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .In        (In),
        .InValid   (InValid),
        .InReady   (InReady),
        .Control   (Control),
        .Out1      (Out1),
        .Out2      (Out2),
        .Out3      (Out3),
        .Out4      (Out4),
        .Out5      (Out5),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .DropCount (DropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        outs[0] = Out1;
        outs[1] = Out2;
        outs[2] = Out3;
        outs[3] = Out4;
        outs[4] = Out5;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare what the DUT shows now, then advance the model by this cycle's handshakes.
    always @(negedge clk) begin
        if (reset) begin
            chk("inready_during_reset", {63'b0, InReady}, 64'd0);
            for (int k = 0; k < 5; k++) exp_q[k].delete();
            exp_drop = 0;
        end else begin
            for (int k = 0; k < 5; k++) m_occ[k] = (exp_q[k].size() != 0);
            if (Control > 3'd4) m_rdy = 1'b1;
            else                m_rdy = !m_occ[Control] || OutReady[Control];
            chk("outvalid", {59'b0, OutValid}, {59'b0, m_occ});
            chk("inready", {63'b0, InReady}, {63'b0, m_rdy});
            chk("dropcount", {56'b0, DropCount}, 64'(exp_drop));
            for (int k = 0; k < 5; k++) begin
                if (OutValid[k] && m_occ[k]) begin
                    chk($sformatf("out%0d_data", k + 1), outs[k], exp_q[k][0]);
                    if (OutReady[k]) void'(exp_q[k].pop_front());
                end
            end
            if (InValid && m_rdy) begin
                if (Control > 3'd4) begin
                    if (exp_drop < 255) exp_drop++;
                end else begin
                    exp_q[Control].push_back(In);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        In       = '0;
        InValid  = 1'b0;
        Control  = '0;
        OutReady = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outvalid", {59'b0, OutValid}, 64'd0);
        chk("reset_dropcount", {56'b0, DropCount}, 64'd0);
        reset = 1'b0;

        // Single word to Out3 straight after reset.
        In = 64'hDEAD_BEEF_0000_0001; Control = 3'b010; InValid = 1'b1;
        step();
        InValid = 1'b0;
        chk("t1_outvalid", {59'b0, OutValid}, 64'b00100);
        chk("t1_out3", Out3, 64'hDEAD_BEEF_0000_0001);
        OutReady = 5'b00100;
        step();
        OutReady = '0;
        chk("t1_drained", {59'b0, OutValid}, 64'd0);

        // Backpressure on a full Out2, then same-cycle drain and refill.
        In = 64'h0000_0000_AAAA_0002; Control = 3'b001; InValid = 1'b1;
        step();
        In = 64'h0000_0000_BBBB_0002;
        #1;
        chk("t2_inready_blocked", {63'b0, InReady}, 64'd0);
        step();
        chk("t2_out2_held", Out2, 64'h0000_0000_AAAA_0002);
        chk("t2_outvalid_held", {59'b0, OutValid}, 64'b00010);
        OutReady = 5'b00010;
        #1;
        chk("t2_inready_refill", {63'b0, InReady}, 64'd1);
        step();
        InValid = 1'b0; OutReady = '0;
        chk("t2_out2_new", Out2, 64'h0000_0000_BBBB_0002);
        chk("t2_outvalid_new", {59'b0, OutValid}, 64'b00010);
        OutReady = 5'b00010;
        step();
        OutReady = '0;

        // Invalid select: dropped, counted, saturating.
        Control = 3'b110; InValid = 1'b1; In = 64'h1234;
        #1;
        chk("t3_inready_drop", {63'b0, InReady}, 64'd1);
        repeat (3) step();
        InValid = 1'b0;
        chk("t3_dropcount_3", {56'b0, DropCount}, 64'd3);
        chk("t3_outvalid", {59'b0, OutValid}, 64'd0);
        InValid = 1'b1;
        repeat (300) step();
        InValid = 1'b0;
        chk("t3_dropcount_sat", {56'b0, DropCount}, 64'hFF);

        // Fill every slot, then drain all in one cycle.
        for (int k = 0; k < 5; k++) begin
            Control = 3'(k); In = 64'(k + 1); InValid = 1'b1;
            step();
        end
        InValid = 1'b0;
        chk("t4_outvalid_full", {59'b0, OutValid}, 64'b11111);
        chk("t4_out1", Out1, 64'h1);
        chk("t4_out2", Out2, 64'h2);
        chk("t4_out3", Out3, 64'h3);
        chk("t4_out4", Out4, 64'h4);
        chk("t4_out5", Out5, 64'h5);
        OutReady = 5'b11111;
        step();
        OutReady = '0;
        chk("t4_outvalid_empty", {59'b0, OutValid}, 64'd0);

        // Reset mid-operation discards buffered words and the drop count.
        reset = 1'b1;
        step();
        reset = 1'b0;
        Control = 3'b000; In = 64'hA1; InValid = 1'b1;
        step();
        Control = 3'b011; In = 64'hA4;
        step();
        Control = 3'b101;
        repeat (7) step();
        InValid = 1'b0;
        chk("t5_dropcount_7", {56'b0, DropCount}, 64'd7);
        chk("t5_outvalid", {59'b0, OutValid}, 64'b01001);
        reset = 1'b1; InValid = 1'b1; Control = 3'b001; In = 64'hCC;
        #1;
        chk("t5_inready_reset", {63'b0, InReady}, 64'd0);
        step();
        reset = 1'b0; InValid = 1'b0;
        chk("t5_outvalid_rst", {59'b0, OutValid}, 64'd0);
        chk("t5_out1_rst", Out1, 64'd0);
        chk("t5_out2_rst", Out2, 64'd0);
        chk("t5_out3_rst", Out3, 64'd0);
        chk("t5_out4_rst", Out4, 64'd0);
        chk("t5_out5_rst", Out5, 64'd0);
        chk("t5_dropcount_rst", {56'b0, DropCount}, 64'd0);
        Control = 3'b100; In = 64'h55; InValid = 1'b1;
        step();
        InValid = 1'b0;
        chk("t5_first_accept_valid", {59'b0, OutValid}, 64'b10000);
        chk("t5_first_accept_out5", Out5, 64'h55);
        OutReady = 5'b10000;
        step();
        OutReady = '0;

        // Random soak against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            InValid  = 1'($urandom_range(0, 1));
            Control  = 3'($urandom_range(0, 7));
            In       = {$urandom, $urandom};
            OutReady = 5'($urandom);
            step();
        end
        InValid  = 1'b0;
        OutReady = 5'b11111;
        repeat (3) step();
        OutReady = '0;
        #3;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("soak_q%0d_empty", k + 1), 64'(exp_q[k].size()), 64'd0);
        end
        chk("soak_outvalid_empty", {59'b0, OutValid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
